// File: rtl/matrix_div_scheduler_if.sv
// ---------------------------------------------------------------------------
// matrix_div_scheduler_if
//
// Bundles the requester-side and engine-side signals of the shared
// matrix_division scheduler so they travel as one port.
//
//   req          N_REQ              per-requester request level
//   divisor_in   N_REQ*DIVISOR_W    per-requester divisor, slice i at
//                                   [i*DIVISOR_WIDTH +: DIVISOR_WIDTH]
//   grant        N_REQ              one-hot owner, steers the operand mux
//   ack          N_REQ              one-cycle completion pulse to the owner
//   err          1                  one-cycle error pulse, coincident with ack
//   busy         1                  scheduler not idle
//   eng_start    1                  engine start pulse
//   eng_divisor  DIVISOR_WIDTH      latched divisor presented to the engine
//   eng_done     1                  engine done level
//
// Modports:
//   master - the scheduler itself (drives grant/ack/err/busy/engine controls)
//   slave  - the surrounding attention block (requesters and engine)
// ---------------------------------------------------------------------------
interface matrix_div_scheduler_if #(
  parameter int N_REQ         = 4,
  parameter int DIVISOR_WIDTH = 8
);

  logic [N_REQ-1:0]               req;
  logic [N_REQ*DIVISOR_WIDTH-1:0] divisor_in;
  logic [N_REQ-1:0]               grant;
  logic [N_REQ-1:0]               ack;
  logic                           err;
  logic                           busy;
  logic                           eng_start;
  logic [DIVISOR_WIDTH-1:0]       eng_divisor;
  logic                           eng_done;

  modport master (
    input  req,
    input  divisor_in,
    input  eng_done,
    output grant,
    output ack,
    output err,
    output busy,
    output eng_start,
    output eng_divisor
  );

  modport slave (
    output req,
    output divisor_in,
    output eng_done,
    input  grant,
    input  ack,
    input  err,
    input  busy,
    input  eng_start,
    input  eng_divisor
  );

endinterface

// File: rtl/matrix_div_scheduler.sv
// ---------------------------------------------------------------------------
// matrix_div_scheduler
//
// Round-robin scheduler sharing one matrix_division engine among N_REQ
// attention-head requesters. It picks a winner, latches that requester's
// divisor onto the engine, fires a one-cycle start, waits for a fresh done
// edge under a watchdog and then acknowledges the owner. A zero divisor is
// rejected without starting the engine.
//
// Ports:
//   clk    in  single clock, rising edge
//   reset  in  asynchronous, active-low reset
//   bus    matrix_div_scheduler_if.master (req, divisor_in, grant, ack, err,
//          busy, eng_start, eng_divisor, eng_done)
//
// Parameters:
//   N_REQ          number of requesters (>= 2)
//   DIVISOR_WIDTH  signed divisor width, matches the engine
//   TIMEOUT        BUSY cycles allowed before the operation is abandoned (>= 2)
//
// All outputs come straight from flops; every output's next value is decided
// in the same combinational block as the next state.
// ---------------------------------------------------------------------------
module matrix_div_scheduler #(
  parameter int N_REQ         = 4,
  parameter int DIVISOR_WIDTH = 8,
  parameter int TIMEOUT       = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  matrix_div_scheduler_if.master  bus
);

  localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY,
    RESP
  } state_t;

  state_t                   state_q, state_d;
  logic [N_REQ-1:0]         grant_q, grant_d;
  logic [N_REQ-1:0]         ack_q, ack_d;
  logic                     err_q, err_d;
  logic                     busy_q, busy_d;
  logic                     engStart_q, engStart_d;
  logic [DIVISOR_WIDTH-1:0] engDivisor_q, engDivisor_d;
  logic [IDX_W-1:0]         owner_q, owner_d;
  logic [IDX_W-1:0]         last_q, last_d;
  logic [TIMER_W-1:0]       timer_q, timer_d;
  logic                     done_q;

  logic                     winFound;
  logic [IDX_W-1:0]         winIdx;
  logic [DIVISOR_WIDTH-1:0] winDivisor;
  logic [N_REQ-1:0]         winOneHot;
  logic [N_REQ-1:0]         ownerOneHot;
  logic                     doneEdge;
  logic                     timerExpired;

  // Round-robin search: start one past the previous owner and wrap, so the
  // requester served last always has the lowest priority. After reset last_q
  // points at N_REQ-1, which makes requester 0 the first candidate.
  always_comb begin
    int cand;
    winFound = 1'b0;
    winIdx   = last_q;
    cand     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(last_q) + k) % N_REQ;
      if (!winFound && bus.req[cand]) begin
        winFound = 1'b1;
        winIdx   = IDX_W'(cand);
      end
    end
  end

  // Winner's divisor slice plus one-hot decodes of the winner and owner.
  always_comb begin
    winDivisor  = bus.divisor_in[int'(winIdx)*DIVISOR_WIDTH +: DIVISOR_WIDTH];
    winOneHot   = {{(N_REQ-1){1'b0}}, 1'b1} << winIdx;
    ownerOneHot = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;
  end

  // Only a fresh rising edge of done counts as completion; a level left high
  // by an earlier operation is ignored because done_q is already set.
  always_comb begin
    doneEdge     = bus.eng_done & ~done_q;
    timerExpired = (timer_q == TIMER_W'(TIMEOUT - 1));
  end

  // Next-state and next-output logic. Everything holds by default except the
  // single-cycle pulses (ack, err, eng_start), which default low. busy is
  // derived from the state being entered so it lines up with the state flop.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ack_d        = '0;
    err_d        = 1'b0;
    engStart_d   = 1'b0;
    engDivisor_d = engDivisor_q;
    owner_d      = owner_q;
    last_d       = last_q;
    timer_d      = timer_q;

    case (state_q)
      IDLE: begin
        if (winFound) begin
          owner_d      = winIdx;
          engDivisor_d = winDivisor;
          grant_d      = winOneHot;
          if (winDivisor != '0) begin
            state_d    = START;
            engStart_d = 1'b1;
          end else begin
            // A zero divisor is answered straight away with an error and
            // the engine is never started.
            state_d = RESP;
            ack_d   = winOneHot;
            err_d   = 1'b1;
          end
        end
      end

      START: begin
        timer_d = '0;
        state_d = BUSY;
      end

      BUSY: begin
        // Completion beats the watchdog when both land in the same cycle.
        if (doneEdge) begin
          state_d = RESP;
          ack_d   = ownerOneHot;
          err_d   = 1'b0;
        end else if (timerExpired) begin
          state_d = RESP;
          ack_d   = ownerOneHot;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      RESP: begin
        last_d  = owner_q;
        grant_d = '0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers. Reset drops any operation in flight with no
  // acknowledge and restores requester 0 as first in line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      ack_q        <= '0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      engStart_q   <= 1'b0;
      engDivisor_q <= '0;
      owner_q      <= '0;
      last_q       <= IDX_W'(N_REQ - 1);
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      engStart_q   <= engStart_d;
      engDivisor_q <= engDivisor_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      timer_q      <= timer_d;
    end
  end

  // done_q tracks the engine's done level in every state so an edge is
  // judged against the value seen one cycle earlier, whatever happened then.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= bus.eng_done;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.ack         = ack_q;
  assign bus.err         = err_q;
  assign bus.busy        = busy_q;
  assign bus.eng_start   = engStart_q;
  assign bus.eng_divisor = engDivisor_q;

endmodule

// File: tb/tb_matrix_div_scheduler.sv
// ---------------------------------------------------------------------------
// tb_matrix_div_scheduler
//
// Self-checking bench for matrix_div_scheduler. A small engine model answers
// each start with a done edge after a chosen delay (or never), and a
// transaction-level model predicts the winner, the error flag and the length
// of each operation from the round-robin and watchdog rules.
// ---------------------------------------------------------------------------
module tb_matrix_div_scheduler;

  localparam int N = 4;
  localparam int W = 8;
  localparam int T = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  matrix_div_scheduler_if #(.N_REQ(N), .DIVISOR_WIDTH(W)) bus ();

  matrix_div_scheduler #(
    .N_REQ(N),
    .DIVISOR_WIDTH(W),
    .TIMEOUT(T)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int engDelay    = 1;
  int mLast       = N - 1;

  // Every comparison funnels through here.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Engine model: on seeing a start pulse it drops done, then raises it
  // engDelay cycles later. A non-positive engDelay leaves done untouched,
  // which models an engine that never answers (possibly with a stale high).
  initial begin
    bus.eng_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.eng_start === 1'b1 && engDelay > 0) begin
        bus.eng_done = 1'b0;
        repeat (engDelay) @(posedge clk);
        #1 bus.eng_done = 1'b1;
      end
    end
  end

  // Reference arbitration: first set bit after the previous owner, wrapping.
  function automatic int pickWinner(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N*W-1:0] randDivisors(input int zeroPct);
    logic [N*W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 99) >= zeroPct)
        v[i*W +: W] = W'($urandom_range(1, 255));
    end
    return v;
  endfunction

  task automatic applyStimulus(input logic [N-1:0] r, input logic [N*W-1:0] d,
                               input int delay);
    bus.req        = r;
    bus.divisor_in = d;
    engDelay       = delay;
  endtask

  task automatic doReset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mLast = N - 1;
  endtask

  // Called at a falling edge while the scheduler is idle with req applied.
  // Follows one operation to its end and leaves the bench at the falling
  // edge of the following idle cycle.
  task automatic runOperation(input string name);
    logic [N-1:0]   reqSnap;
    logic [N*W-1:0] divSnap;
    logic [W-1:0]   expDiv;
    logic [N-1:0]   expOh;
    logic [N-1:0]   ackVal;
    logic           errVal;
    logic           zeroPath, doneInTime, expErr;
    int             w, expBusy;
    int             busyCycles, starts, startCycle, acks, ackCycle;
    int             grantBad, divBad, strayErr;

    reqSnap    = bus.req;
    divSnap    = bus.divisor_in;
    w          = pickWinner(reqSnap, mLast);
    if (w < 0) begin
      checkOutput({name, ".noRequest"}, 32'(reqSnap), 32'(1));
      return;
    end
    expDiv     = divSnap[w*W +: W];
    expOh      = '0;
    expOh[w]   = 1'b1;
    zeroPath   = (expDiv == '0);
    doneInTime = (engDelay >= 1) && (engDelay <= T);
    expErr     = zeroPath || !doneInTime;
    expBusy    = zeroPath ? 1 : 2 + (doneInTime ? engDelay : T);

    @(negedge clk);
    checkOutput({name, ".busyRise"}, 32'(bus.busy), 32'(1));
    checkOutput({name, ".grant"}, 32'(bus.grant), 32'(expOh));
    checkOutput({name, ".engDivisor"}, 32'(bus.eng_divisor), 32'(expDiv));

    busyCycles = 0; starts = 0; startCycle = -1; acks = 0; ackCycle = -1;
    grantBad = 0; divBad = 0; strayErr = 0; ackVal = '0; errVal = 1'b0;
    while (bus.busy === 1'b1 && busyCycles < T + 10) begin
      busyCycles++;
      if (bus.grant !== expOh) grantBad++;
      if (bus.eng_divisor !== expDiv) divBad++;
      if (bus.eng_start === 1'b1) begin
        starts++;
        startCycle = busyCycles;
      end
      if (bus.ack !== '0) begin
        acks++;
        ackCycle = busyCycles;
        ackVal   = bus.ack;
        errVal   = bus.err;
      end else if (bus.err !== 1'b0) begin
        strayErr++;
      end
      // Divisors must only matter at arbitration, and a requester letting
      // go after its grant must not abort the operation.
      if (busyCycles == 1) begin
        bus.divisor_in = randDivisors(0);
        if ($urandom_range(0, 1) == 1) bus.req[w] = 1'b0;
      end
      @(negedge clk);
    end

    checkOutput({name, ".busyCycles"}, 32'(busyCycles), 32'(expBusy));
    checkOutput({name, ".startCount"}, 32'(starts), zeroPath ? 32'(0) : 32'(1));
    if (!zeroPath)
      checkOutput({name, ".startCycle"}, 32'(startCycle), 32'(1));
    checkOutput({name, ".ackCount"}, 32'(acks), 32'(1));
    checkOutput({name, ".ackInLastBusy"}, 32'(ackCycle), 32'(expBusy));
    checkOutput({name, ".ackValue"}, 32'(ackVal), 32'(expOh));
    checkOutput({name, ".err"}, 32'(errVal), 32'(expErr));
    checkOutput({name, ".strayErr"}, 32'(strayErr), 32'(0));
    checkOutput({name, ".grantHeld"}, 32'(grantBad), 32'(0));
    checkOutput({name, ".divisorHeld"}, 32'(divBad), 32'(0));
    checkOutput({name, ".idleGrant"}, 32'(bus.grant), 32'(0));
    checkOutput({name, ".idleAck"}, 32'(bus.ack), 32'(0));
    checkOutput({name, ".idleDivisorKept"}, 32'(bus.eng_divisor), 32'(expDiv));
    mLast = w;
  endtask

  // Hard bound on total run time.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    logic [N*W-1:0] d;
    logic [N-1:0]   r;
    int             delay, ackSeen;

    reset = 1'b0;
    applyStimulus('0, '0, 5);
    repeat (3) @(negedge clk);
    checkOutput("reset.grant", 32'(bus.grant), 32'(0));
    checkOutput("reset.ack", 32'(bus.ack), 32'(0));
    checkOutput("reset.err", 32'(bus.err), 32'(0));
    checkOutput("reset.busy", 32'(bus.busy), 32'(0));
    checkOutput("reset.engStart", 32'(bus.eng_start), 32'(0));
    checkOutput("reset.engDivisor", 32'(bus.eng_divisor), 32'(0));
    reset = 1'b1;
    mLast = N - 1;
    @(negedge clk);

    $display("[TB] single request");
    d = '0;
    d[0*W +: W] = 8'd2;
    applyStimulus(4'b0001, d, 5);
    runOperation("single");
    applyStimulus('0, '0, 5);
    repeat (2) @(negedge clk);

    $display("[TB] round robin");
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b1111, randDivisors(0), 3);
      runOperation($sformatf("rr%0d", i));
    end

    $display("[TB] fairness after reset");
    applyStimulus('0, '0, 3);
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b1010, randDivisors(0), 3);
      runOperation($sformatf("fair%0d", i));
    end

    $display("[TB] zero divisor");
    applyStimulus('0, '0, 3);
    doReset();
    d = randDivisors(0);
    d[2*W +: W] = '0;
    applyStimulus(4'b0100, d, 3);
    runOperation("zeroDiv");

    $display("[TB] timeout and stale done");
    applyStimulus(4'b0001, randDivisors(0), 2);
    runOperation("leaveDoneHigh");
    applyStimulus(4'b0010, randDivisors(0), -1);
    runOperation("staleTimeout");
    applyStimulus(4'b0100, randDivisors(0), T);
    runOperation("doneOnLastBusy");
    applyStimulus(4'b1000, randDivisors(0), T + 1);
    runOperation("doneTooLate");

    $display("[TB] reset mid-operation");
    applyStimulus(4'b0100, randDivisors(0), -1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("midReset.grant", 32'(bus.grant), 32'(0));
    checkOutput("midReset.busy", 32'(bus.busy), 32'(0));
    checkOutput("midReset.engStart", 32'(bus.eng_start), 32'(0));
    ackSeen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.ack !== '0) ackSeen++;
    end
    checkOutput("midReset.noAck", 32'(ackSeen), 32'(0));
    reset = 1'b1;
    mLast = N - 1;
    applyStimulus(4'b0011, randDivisors(0), 2);
    runOperation("afterReset");

    $display("[TB] randomized operations");
    for (int i = 0; i < 30; i++) begin
      r = N'($urandom_range(1, (1 << N) - 1));
      delay = $urandom_range(0, T + 1);
      if (delay == 0) delay = -1;
      applyStimulus(r, randDivisors(25), delay);
      runOperation($sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
